uart_line_buffer: RTL and testbench
===================================

// Module: uart_line_buffer
// PURPOSE
//  Parametrised line assembler between the uart RX stream and on-chip consumers.
//  - Collects received bytes into a CHARACTER_COUNT-deep character register until TERM_CHAR arrives.
//  - Supports backspace editing and overflow truncation.
//  - Presents the completed line on a valid/ready handshake and back-pressures the UART while a line is pending.
// PARAMETERS
//  DATA_WIDTH       8      bits per character
//  CHARACTER_COUNT  16     max characters stored per line (>=2)
//  TERM_CHAR        8'h0D  line terminator; consumed, never stored
//  BS_CHAR          8'h08  backspace; removes last stored character
//  EMIT_EMPTY       0      1: a terminator with zero stored chars emits an empty line
// PORTS
//  clk            in   1                           system clock
//  reset_n        in   1                           async active-low reset
//  ena            in   1                           global enable; low = freeze (no accepts, no state change)
//  rx_data        in   DATA_WIDTH                  byte from uart RX
//  rx_valid       in   1                           rx_data valid
//  rx_ready       out  1                           byte accepted when rx_valid&rx_ready
//  line_data      out  CHARACTER_COUNT*DATA_WIDTH  char i at [i*DATA_WIDTH +: DATA_WIDTH], i=0 oldest
//  line_len       out  LEN_W                       stored chars; LEN_W=$clog2(CHARACTER_COUNT+1)
//  line_overflow  out  1                           chars were dropped from this line
//  line_valid     out  1                           line presented
//  line_ready     in   1                           consumer takes line when line_valid&line_ready
//  tx_data        out  DATA_WIDTH                  echo byte (0 when echo compiled out)
//  tx_valid       out  1                           echo valid (0 when echo compiled out)
//  tx_ready       in   1                           uart TX ready
// BEHAVIOUR
//  Reset (async, reset_n=0): state=COLLECT; line_data=0, line_len=0, line_overflow=0, line_valid=0, tx_valid=0, tx_data=0; rx_ready=0 while in reset.
//  Accept = ena & rx_valid & rx_ready. Unaccepted bytes have no effect.
//  States:
//   COLLECT: rx_ready=ena (& echo slot free).
//    - Ordinary byte, count<CHARACTER_COUNT: store at slot count, count+1.
//    - Ordinary byte, count==CHARACTER_COUNT: drop, set overflow, ->DISCARD.
//    - BS_CHAR, count>0: zero slot count-1, count-1. BS_CHAR at count 0: ignored.
//    - TERM_CHAR, count>0 or EMIT_EMPTY: ->LINE_READY. Otherwise ignored.
//   DISCARD: rx_ready as COLLECT; all bytes dropped (BS included) until TERM_CHAR, then ->LINE_READY.
//   LINE_READY: line_valid=1, rx_ready=0. Outputs stable while line_ready=0.
//    - On line_valid&line_ready: clear slots, count and overflow; ->COLLECT.
//  Latency: line_valid rises the cycle after TERM_CHAR is accepted. rx_ready rises the cycle after the line handshake.
//  line_data, line_len and line_overflow are registered and track the buffer continuously. Unused slots always read 0.
//  Simultaneous events: BS and overflow are mutually exclusive per byte. No byte is accepted in the handshake cycle.
//  Reset mid-line or mid-handshake: the line is discarded and no line_valid is produced.
// CONFIGURATION
//  UART_LINE_ECHO_EN defined:
//   - Every accepted byte (including dropped bytes, BS and TERM) is loaded into a one-entry echo register.
//   - tx_valid=1 from the next cycle until tx_valid&tx_ready.
//   - rx_ready is additionally gated by (!tx_valid | tx_ready).
//  UART_LINE_ECHO_EN undefined: tx_valid=0 and tx_data=0 constant; tx_ready ignored; no echo register.
// STRUCTURE
//  Package uart_pkg:
//   - typedef enum logic [1:0] {LB_COLLECT, LB_DISCARD, LB_LINE_READY} line_state_t
//   - localparams ASCII_CR=8'h0D, ASCII_BS=8'h08
//  Single module; no sub-module (echo register is inline, under `ifdef).
// TESTING
//  1. CHARACTER_COUNT=4, send 48,49,0D -> line_valid=1 next cycle, line_len=2, line_data=32'h0000_4948, line_overflow=0.
//  2. Hold line_ready=0 10 cycles -> rx_ready=0 and outputs stable; pulse line_ready -> line_len=0, line_data=0, rx_ready=1 next cycle.
//  3. Send "ABCDEF\r" (41..46,0D) -> line_len=4, line_data=32'h4443_4241, line_overflow=1.
//  4. Send 08,41,42,08,43,0D -> line_len=2, line_data[15:0]=16'h4341 (leading BS ignored).
//  5. EMIT_EMPTY=0, send 0D -> line_valid stays 0. EMIT_EMPTY=1 -> line_valid=1, line_len=0.
//  6. UART_LINE_ECHO_EN, tx_ready=0, send 41 -> tx_valid=1, tx_data=41, rx_ready=0. Assert tx_ready -> tx_valid=0. Reset mid-line -> all outputs 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and character constants for the UART line buffer.
// Provides the line assembler state encoding and ASCII control codes.
package uart_pkg;

    typedef enum logic [1:0] {
        LB_COLLECT,
        LB_DISCARD,
        LB_LINE_READY
    } line_state_t;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_BS = 8'h08;

endpackage

// File: rtl/uart_line_buffer.sv
// Line assembler between a UART RX byte stream and on-chip consumers.
// Collects bytes into a fixed-depth character register until TERM_CHAR,
// supports backspace editing and overflow truncation, and presents the
// finished line on a valid/ready handshake while stalling the RX side.
// Ports:
//   clk, reset_n          clock, async active-low reset
//   ena                   global enable; low freezes all state
//   rx_data/valid/ready   incoming byte stream
//   line_data/len/overflow/valid/ready  completed line handshake
//   tx_data/valid/ready   echo stream
// Optional echo register is built when UART_LINE_ECHO_EN is defined;
// otherwise tx_valid and tx_data are tied to zero.
module uart_line_buffer
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CHARACTER_COUNT = 16,
    parameter logic [DATA_WIDTH-1:0] TERM_CHAR = DATA_WIDTH'(ASCII_CR),
    parameter logic [DATA_WIDTH-1:0] BS_CHAR = DATA_WIDTH'(ASCII_BS),
    parameter bit EMIT_EMPTY = 1'b0,
    localparam int LEN_W = $clog2(CHARACTER_COUNT + 1)
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic                                  ena,
    input  logic [DATA_WIDTH-1:0]                 rx_data,
    input  logic                                  rx_valid,
    output logic                                  rx_ready,
    output logic [CHARACTER_COUNT*DATA_WIDTH-1:0] line_data,
    output logic [LEN_W-1:0]                      line_len,
    output logic                                  line_overflow,
    output logic                                  line_valid,
    input  logic                                  line_ready,
    output logic [DATA_WIDTH-1:0]                 tx_data,
    output logic                                  tx_valid,
    input  logic                                  tx_ready
);

    localparam int BUF_W = CHARACTER_COUNT * DATA_WIDTH;
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(CHARACTER_COUNT);

    line_state_t state_q, state_d;
    logic [BUF_W-1:0] buf_q, buf_d;
    logic [LEN_W-1:0] count_q, count_d;
    logic ovf_q, ovf_d;
    logic accept;
    logic echo_free;
    logic is_term;
    logic is_bs;

    // rx_ready drops combinationally during reset so no byte slips in.
    assign rx_ready = reset_n & ena & (state_q != LB_LINE_READY) & echo_free;
    assign accept = ena & rx_valid & rx_ready;
    assign is_term = (rx_data == TERM_CHAR);
    assign is_bs = (rx_data == BS_CHAR);

    assign line_data = buf_q;
    assign line_len = count_q;
    assign line_overflow = ovf_q;
    assign line_valid = (state_q == LB_LINE_READY);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= LB_COLLECT;
            buf_q <= '0;
            count_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q <= buf_d;
            count_q <= count_d;
            ovf_q <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        buf_d = buf_q;
        count_d = count_q;
        ovf_d = ovf_q;
        unique case (state_q)
            LB_COLLECT: begin
                if (accept) begin
                    if (is_term) begin
                        if ((count_q != '0) || EMIT_EMPTY) begin
                            state_d = LB_LINE_READY;
                        end
                    end else if (is_bs) begin
                        if (count_q != '0) begin
                            buf_d[(int'(count_q) - 1)*DATA_WIDTH +: DATA_WIDTH] = '0;
                            count_d = count_q - 1'b1;
                        end
                    end else if (count_q < MAX_LEN) begin
                        buf_d[int'(count_q)*DATA_WIDTH +: DATA_WIDTH] = rx_data;
                        count_d = count_q + 1'b1;
                    end else begin
                        // Line is full: truncate and swallow the rest.
                        ovf_d = 1'b1;
                        state_d = LB_DISCARD;
                    end
                end
            end
            LB_DISCARD: begin
                if (accept && is_term) begin
                    state_d = LB_LINE_READY;
                end
            end
            LB_LINE_READY: begin
                if (ena && line_ready) begin
                    buf_d = '0;
                    count_d = '0;
                    ovf_d = 1'b0;
                    state_d = LB_COLLECT;
                end
            end
            default: begin
                state_d = LB_COLLECT;
            end
        endcase
    end

`ifdef UART_LINE_ECHO_EN
    logic tx_valid_q;
    logic [DATA_WIDTH-1:0] tx_data_q;

    // A new byte may enter only if the echo slot drains this cycle.
    assign echo_free = !tx_valid_q || tx_ready;
    assign tx_valid = tx_valid_q;
    assign tx_data = tx_data_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_valid_q <= 1'b0;
            tx_data_q <= '0;
        end else if (accept) begin
            tx_valid_q <= 1'b1;
            tx_data_q <= rx_data;
        end else if (ena && tx_ready) begin
            tx_valid_q <= 1'b0;
        end
    end
`else
    logic unused_tx_ready;

    assign unused_tx_ready = tx_ready;
    assign echo_free = 1'b1;
    assign tx_valid = 1'b0;
    assign tx_data = '0;
`endif

endmodule

// File: tb/tb_uart_line_buffer.sv
// Self-checking bench for uart_line_buffer with CHARACTER_COUNT=4.
// Table vectors, directed corner sequences and a randomized run vs a queue model.
module tb_uart_line_buffer;

    localparam int DW = 8;
    localparam int CC = 4;
    localparam int LW = $clog2(CC + 1);

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic ena = 1'b1;
    logic [DW-1:0] rx_data = '0;
    logic rx_valid = 1'b0;
    logic rx_ready;
    logic [CC*DW-1:0] line_data;
    logic [LW-1:0] line_len;
    logic line_overflow;
    logic line_valid;
    logic line_ready = 1'b0;
    logic [DW-1:0] tx_data;
    logic tx_valid;
    logic tx_ready = 1'b1;

    logic [DW-1:0] rx_data_e = '0;
    logic rx_valid_e = 1'b0;
    logic rx_ready_e;
    logic [CC*DW-1:0] line_data_e;
    logic [LW-1:0] line_len_e;
    logic line_overflow_e;
    logic line_valid_e;
    logic line_ready_e = 1'b0;
    logic [DW-1:0] tx_data_e;
    logic tx_valid_e;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_line_buffer #(
        .DATA_WIDTH(DW),
        .CHARACTER_COUNT(CC),
        .EMIT_EMPTY(1'b0)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .ena(ena),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .line_data(line_data),
        .line_len(line_len),
        .line_overflow(line_overflow),
        .line_valid(line_valid),
        .line_ready(line_ready),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready)
    );

    uart_line_buffer #(
        .DATA_WIDTH(DW),
        .CHARACTER_COUNT(CC),
        .EMIT_EMPTY(1'b1)
    ) dut_e (
        .clk(clk),
        .reset_n(reset_n),
        .ena(ena),
        .rx_data(rx_data_e),
        .rx_valid(rx_valid_e),
        .rx_ready(rx_ready_e),
        .line_data(line_data_e),
        .line_len(line_len_e),
        .line_overflow(line_overflow_e),
        .line_valid(line_valid_e),
        .line_ready(line_ready_e),
        .tx_data(tx_data_e),
        .tx_valid(tx_valid_e),
        .tx_ready(tx_ready)
    );

    // Reference model: line contents as a queue plus flags.
    logic [7:0] mq[$];
    bit m_ovf;
    bit m_disc;
    bit m_pend;

    task automatic model_clear();
        mq.delete();
        m_ovf = 0;
        m_disc = 0;
        m_pend = 0;
    endtask

    task automatic model_accept(input logic [7:0] b);
        if (m_disc) begin
            if (b == 8'h0D) m_pend = 1;
        end else if (b == 8'h0D) begin
            if (mq.size() > 0) m_pend = 1;
        end else if (b == 8'h08) begin
            if (mq.size() > 0) void'(mq.pop_back());
        end else if (mq.size() < CC) begin
            mq.push_back(b);
        end else begin
            m_ovf = 1;
            m_disc = 1;
        end
    endtask

    function automatic logic [31:0] model_data();
        logic [31:0] d;
        d = '0;
        for (int i = 0; i < mq.size(); i++) d[i*8 +: 8] = mq[i];
        return d;
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, "_len"}, 64'(line_len), 64'(mq.size()));
        chk({tag, "_data"}, 64'(line_data), 64'(model_data()));
        chk({tag, "_ovf"}, 64'(line_overflow), 64'(m_ovf));
        chk({tag, "_valid"}, 64'(line_valid), 64'(m_pend));
    endtask

    // Called and returns just after a rising edge.
    task automatic send_byte(input logic [7:0] b);
        bit got;
        got = 0;
        rx_data = b;
        rx_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (rx_ready) begin
                got = 1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!got) begin
            rx_valid = 1'b0;
            chk("rx_ready_timeout", 64'd0, 64'd1);
            @(posedge clk);
            #1;
        end else begin
            @(posedge clk);
            #1;
            rx_valid = 1'b0;
            model_accept(b);
            @(negedge clk);
            chk_model("byte");
`ifndef UART_LINE_ECHO_EN
            chk("tx_valid_off", 64'(tx_valid), 64'd0);
`endif
            @(posedge clk);
            #1;
        end
    endtask

    task automatic handshake();
        line_ready = 1'b1;
        @(negedge clk);
        chk("hs_valid", 64'(line_valid), 64'd1);
        chk("hs_rx_ready_low", 64'(rx_ready), 64'd0);
        @(posedge clk);
        #1;
        line_ready = 1'b0;
        model_clear();
        @(negedge clk);
        chk_model("post_hs");
        chk("post_hs_rx_ready", 64'(rx_ready), 64'd1);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [7:0] seq[8];
        int n;
        int len;
        logic [31:0] data;
        bit ovf;
        bit valid;
    } vec_t;

    vec_t tv[6];

    initial begin
        #200000;
        $display("FAIL watchdog: timeout");
        $fatal(1);
    end

    initial begin
        logic [31:0] hold_data;
        logic [LW-1:0] hold_len;

        tv[0].seq = '{8'h48, 8'h49, 8'h0D, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0};
        tv[0].n = 3; tv[0].len = 2; tv[0].data = 32'h0000_4948;
        tv[0].ovf = 0; tv[0].valid = 1;
        tv[1].seq = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h0D, 8'h0};
        tv[1].n = 7; tv[1].len = 4; tv[1].data = 32'h4443_4241;
        tv[1].ovf = 1; tv[1].valid = 1;
        tv[2].seq = '{8'h08, 8'h41, 8'h42, 8'h08, 8'h43, 8'h0D, 8'h0, 8'h0};
        tv[2].n = 6; tv[2].len = 2; tv[2].data = 32'h0000_4341;
        tv[2].ovf = 0; tv[2].valid = 1;
        tv[3].seq = '{8'h0D, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0};
        tv[3].n = 1; tv[3].len = 0; tv[3].data = 32'h0;
        tv[3].ovf = 0; tv[3].valid = 0;
        tv[4].seq = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h0D, 8'h0, 8'h0, 8'h0};
        tv[4].n = 5; tv[4].len = 4; tv[4].data = 32'h4443_4241;
        tv[4].ovf = 0; tv[4].valid = 1;
        tv[5].seq = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h08, 8'h0D, 8'h0};
        tv[5].n = 7; tv[5].len = 4; tv[5].data = 32'h4443_4241;
        tv[5].ovf = 1; tv[5].valid = 1;

        model_clear();

        // Reset state with a byte already offered.
        rx_valid = 1'b1;
        rx_data = 8'h41;
        #12;
        chk("rst_rx_ready", 64'(rx_ready), 64'd0);
        chk("rst_len", 64'(line_len), 64'd0);
        chk("rst_data", 64'(line_data), 64'd0);
        chk("rst_valid", 64'(line_valid), 64'd0);
        chk("rst_ovf", 64'(line_overflow), 64'd0);
        chk("rst_tx_valid", 64'(tx_valid), 64'd0);
        chk("rst_tx_data", 64'(tx_data), 64'd0);
        rx_valid = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Table-driven vectors.
        foreach (tv[v]) begin
            for (int j = 0; j < tv[v].n; j++) send_byte(tv[v].seq[j]);
            @(negedge clk);
            chk("vec_valid", 64'(line_valid), 64'(tv[v].valid));
            chk("vec_len", 64'(line_len), 64'(tv[v].len));
            chk("vec_data", 64'(line_data), 64'(tv[v].data));
            chk("vec_ovf", 64'(line_overflow), 64'(tv[v].ovf));
            @(posedge clk);
            #1;
            if (tv[v].valid) begin
                for (int h = 0; h < ((v == 0) ? 10 : 2); h++) begin
                    @(negedge clk);
                    chk("hold_rx_ready", 64'(rx_ready), 64'd0);
                    chk("hold_valid", 64'(line_valid), 64'd1);
                    chk("hold_data", 64'(line_data), 64'(tv[v].data));
                    chk("hold_len", 64'(line_len), 64'(tv[v].len));
                    @(posedge clk);
                    #1;
                end
                handshake();
            end
        end

        // Freeze: no accepts and no handshake while ena is low.
        send_byte(8'h41);
        ena = 1'b0;
        rx_data = 8'h42;
        rx_valid = 1'b1;
        @(negedge clk);
        chk("frz_rx_ready", 64'(rx_ready), 64'd0);
        @(posedge clk);
        @(negedge clk);
        chk("frz_len", 64'(line_len), 64'd1);
        rx_valid = 1'b0;
        ena = 1'b1;
        @(posedge clk);
        #1;
        send_byte(8'h0D);
        ena = 1'b0;
        line_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("frz_hs_valid", 64'(line_valid), 64'd1);
        line_ready = 1'b0;
        ena = 1'b1;
        @(posedge clk);
        #1;
        handshake();

        // Reset mid-line discards the partial line.
        send_byte(8'h41);
        send_byte(8'h42);
        reset_n = 1'b0;
        #2;
        chk("mid_rst_len", 64'(line_len), 64'd0);
        chk("mid_rst_data", 64'(line_data), 64'd0);
        chk("mid_rst_rx_ready", 64'(rx_ready), 64'd0);
        model_clear();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        send_byte(8'h0D);

        // Reset mid-handshake: pending line vanishes.
        send_byte(8'h43);
        send_byte(8'h0D);
        reset_n = 1'b0;
        #2;
        chk("hs_rst_valid", 64'(line_valid), 64'd0);
        chk("hs_rst_len", 64'(line_len), 64'd0);
        model_clear();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // EMIT_EMPTY=1 instance: bare terminator yields an empty line.
        rx_data_e = 8'h0D;
        rx_valid_e = 1'b1;
        @(negedge clk);
        chk("emp_rx_ready", 64'(rx_ready_e), 64'd1);
        @(posedge clk);
        #1;
        rx_valid_e = 1'b0;
        @(negedge clk);
        chk("emp_valid", 64'(line_valid_e), 64'd1);
        chk("emp_len", 64'(line_len_e), 64'd0);
        @(posedge clk);
        #1;
        line_ready_e = 1'b1;
        @(posedge clk);
        #1;
        line_ready_e = 1'b0;
        @(negedge clk);
        chk("emp_done", 64'(line_valid_e), 64'd0);
        @(posedge clk);
        #1;

`ifdef UART_LINE_ECHO_EN
        tx_ready = 1'b0;
        send_byte(8'h41);
        @(negedge clk);
        chk("echo_valid", 64'(tx_valid), 64'd1);
        chk("echo_data", 64'(tx_data), 64'h41);
        chk("echo_stall", 64'(rx_ready), 64'd0);
        @(posedge clk);
        #1;
        tx_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("echo_drain", 64'(tx_valid), 64'd0);
        @(posedge clk);
        #1;
        send_byte(8'h0D);
        handshake();
`else
        chk("noecho_tx_valid", 64'(tx_valid), 64'd0);
        chk("noecho_tx_data", 64'(tx_data), 64'd0);
`endif

        // Randomized traffic against the queue model.
        for (int i = 0; i < 400; i++) begin
            if (m_pend) begin
                hold_data = line_data;
                hold_len = line_len;
                for (int h = 0; h < int'($urandom_range(0, 3)); h++) begin
                    @(negedge clk);
                    chk("rnd_hold_data", 64'(line_data), 64'(model_data()));
                    chk("rnd_hold_rx_ready", 64'(rx_ready), 64'd0);
                    @(posedge clk);
                    #1;
                end
                handshake();
            end else begin
                int r;
                r = int'($urandom_range(0, 9));
                if (r < 2) send_byte(8'h0D);
                else if (r == 2) send_byte(8'h08);
                else send_byte(8'h41 + 8'($urandom_range(0, 25)));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
